// File: rtl/reg_file_sb.sv
// reg_file_sb: two-read / one-write integer register file with same-cycle
// write-through bypass, optional hardwired-zero r0, and a per-register busy
// scoreboard (issue sets, writeback clears, flush clears all) feeding RAW
// hazard detection in decode.
module reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int NREGS    = 32,
  parameter int ADDR_W   = $clog2(NREGS),
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_addr_1,
  input  logic [ADDR_W-1:0] read_addr_2,
  output logic [DATA_W-1:0] read_data_1,
  output logic [DATA_W-1:0] read_data_2,
  output logic              read_busy_1,
  output logic              read_busy_2,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic              flush,
  output logic [ADDR_W:0]   busy_count
);

  localparam logic ZERO_EN = (ZERO_REG != 0);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [NREGS-1:0]  busy_q;
  logic [NREGS-1:0]  busy_d;
  logic [ADDR_W:0]   busy_count_q;
  logic [ADDR_W:0]   busy_count_d;

  logic wr_ok;
  logic iss_ok;

  // Writes and issues targeting a hardwired r0 are suppressed.
  always_comb begin
    wr_ok  = write_en && !(ZERO_EN && (write_addr == '0));
    iss_ok = issue_en && !(ZERO_EN && (issue_addr == '0));
  end

  // Register data next state: single write port.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wr_ok) begin
      regs_d[write_addr] = write_data;
    end
  end

  // Busy next state: flush dominates; otherwise writeback clears, then issue
  // sets so a new producer to the same register keeps it pending.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (wr_ok) begin
        busy_d[write_addr] = 1'b0;
      end
      if (iss_ok) begin
        busy_d[issue_addr] = 1'b1;
      end
    end
  end

  // Population count of the next-state busy vector, registered alongside it.
  always_comb begin
    busy_count_d = '0;
    for (int i = 0; i < NREGS; i++) begin
      busy_count_d = busy_count_d + {{ADDR_W{1'b0}}, busy_d[i]};
    end
  end

  // State registers; async reset clears data, busy bits and the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q       <= '0;
      busy_count_q <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
    end
  end

  // Read port 1: array read, then write bypass, then r0 override.
  always_comb begin
    read_data_1 = regs_q[read_addr_1];
    if (wr_ok && (write_addr == read_addr_1)) begin
      read_data_1 = write_data;
    end
    if (ZERO_EN && (read_addr_1 == '0)) begin
      read_data_1 = '0;
    end
  end

  // Read port 2: same structure as port 1.
  always_comb begin
    read_data_2 = regs_q[read_addr_2];
    if (wr_ok && (write_addr == read_addr_2)) begin
      read_data_2 = write_data;
    end
    if (ZERO_EN && (read_addr_2 == '0)) begin
      read_data_2 = '0;
    end
  end

  // Busy flags come straight from registered state; no bypass of a
  // same-cycle issue or writeback.
  always_comb begin
    read_busy_1 = busy_q[read_addr_1] && !(ZERO_EN && (read_addr_1 == '0));
    read_busy_2 = busy_q[read_addr_2] && !(ZERO_EN && (read_addr_2 == '0));
  end

  assign busy_count = busy_count_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: one instance with defaults (32x32, r0
// hardwired) and one with DATA_W=16, NREGS=8, ZERO_REG=0. Expected values are
// queued when stimulus is driven and popped when outputs are sampled.
module tb_reg_file_sb;

  logic clk;
  logic reset;

  // Instance A: defaults
  logic        a_we;
  logic [4:0]  a_wa;
  logic [31:0] a_wd;
  logic [4:0]  a_ra1, a_ra2;
  logic [31:0] a_rd1, a_rd2;
  logic        a_rb1, a_rb2;
  logic        a_ie;
  logic [4:0]  a_ia;
  logic        a_fl;
  logic [5:0]  a_bc;

  // Instance B: 16-bit, 8 registers, ordinary r0
  logic        b_we;
  logic [2:0]  b_wa;
  logic [15:0] b_wd;
  logic [2:0]  b_ra1, b_ra2;
  logic [15:0] b_rd1, b_rd2;
  logic        b_rb1, b_rb2;
  logic        b_ie;
  logic [2:0]  b_ia;
  logic        b_fl;
  logic [3:0]  b_bc;

  reg_file_sb dut_a (
    .clk(clk), .reset(reset),
    .write_en(a_we), .write_addr(a_wa), .write_data(a_wd),
    .read_addr_1(a_ra1), .read_addr_2(a_ra2),
    .read_data_1(a_rd1), .read_data_2(a_rd2),
    .read_busy_1(a_rb1), .read_busy_2(a_rb2),
    .issue_en(a_ie), .issue_addr(a_ia),
    .flush(a_fl), .busy_count(a_bc)
  );

  reg_file_sb #(.DATA_W(16), .NREGS(8), .ZERO_REG(0)) dut_b (
    .clk(clk), .reset(reset),
    .write_en(b_we), .write_addr(b_wa), .write_data(b_wd),
    .read_addr_1(b_ra1), .read_addr_2(b_ra2),
    .read_data_1(b_rd1), .read_data_2(b_rd2),
    .read_busy_1(b_rb1), .read_busy_2(b_rb2),
    .issue_en(b_ie), .issue_addr(b_ia),
    .flush(b_fl), .busy_count(b_bc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic push(input string tag, input logic [31:0] e);
    exp_t x;
    x.tag = tag;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t x;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_underflow observed=%h expected=<none>", obs);
    end else begin
      x = sb.pop_front();
      assert (obs === x.exp) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", x.tag, obs, x.exp);
      end
    end
  endtask

  task automatic a_idle();
    a_we = 1'b0; a_wa = '0; a_wd = '0; a_ie = 1'b0; a_ia = '0; a_fl = 1'b0;
  endtask

  task automatic b_idle();
    b_we = 1'b0; b_wa = '0; b_wd = '0; b_ie = 1'b0; b_ia = '0; b_fl = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    a_idle(); a_ra1 = '0; a_ra2 = '0;
    b_idle(); b_ra1 = '0; b_ra2 = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // ---------------- Instance A ----------------
    @(negedge clk); #2;
    push("a_reset_busy_count", 32'd0);  check({26'd0, a_bc});
    push("a_reset_read_busy1", 32'd0);  check({31'd0, a_rb1});

    // Write r5 and issue r5 in the same cycle: data lands, busy set wins
    @(negedge clk);
    a_we = 1'b1; a_wa = 5'd5; a_wd = 32'hDEADBEEF; a_ie = 1'b1; a_ia = 5'd5;
    @(negedge clk);
    a_idle(); a_ra1 = 5'd5; #2;
    push("a_r5_written", 32'hDEADBEEF); check(a_rd1);
    push("a_r5_busy_count", 32'd1);     check({26'd0, a_bc});

    // Asynchronous reset mid-cycle
    #1 reset = 1'b1;
    #1;
    push("a_async_reset_data", 32'd0);  check(a_rd1);
    push("a_async_reset_count", 32'd0); check({26'd0, a_bc});
    push("a_async_reset_busy", 32'd0);  check({31'd0, a_rb1});
    @(negedge clk);
    reset = 1'b0;

    // Write with same-cycle bypass on r7
    @(negedge clk);
    a_we = 1'b1; a_wa = 5'd7; a_wd = 32'h12345678; a_ra1 = 5'd7; #2;
    push("a_r7_bypass", 32'h12345678);  check(a_rd1);
    @(negedge clk);
    a_idle(); #2;
    push("a_r7_stored", 32'h12345678);  check(a_rd1);

    // Hardwired r0: write and issue are ignored
    @(negedge clk);
    a_we = 1'b1; a_wa = 5'd0; a_wd = 32'hFFFFFFFF; a_ie = 1'b1; a_ia = 5'd0;
    a_ra1 = 5'd0; #2;
    push("a_r0_bypass_blocked", 32'd0); check(a_rd1);
    @(negedge clk);
    a_idle(); #2;
    push("a_r0_stored", 32'd0);         check(a_rd1);
    push("a_r0_busy", 32'd0);           check({31'd0, a_rb1});
    push("a_r0_busy_count", 32'd0);     check({26'd0, a_bc});

    // Scoreboard: issue r3 then r9
    @(negedge clk);
    a_ie = 1'b1; a_ia = 5'd3;
    @(negedge clk);
    a_ia = 5'd9; #2;
    push("a_count_after_r3", 32'd1);    check({26'd0, a_bc});
    @(negedge clk);
    a_idle(); a_ra2 = 5'd9;
    a_we = 1'b1; a_wa = 5'd3; a_wd = 32'h00000033; a_ra1 = 5'd3; #2;
    push("a_count_after_r9", 32'd2);    check({26'd0, a_bc});
    push("a_r9_busy", 32'd1);           check({31'd0, a_rb2});
    push("a_r3_busy_no_bypass", 32'd1); check({31'd0, a_rb1});
    push("a_r3_data_bypass", 32'h33);   check(a_rd1);
    @(negedge clk);
    a_idle(); #2;
    push("a_r3_busy_cleared", 32'd0);   check({31'd0, a_rb1});
    push("a_count_after_wb", 32'd1);    check({26'd0, a_bc});

    // Simultaneous issue and write to busy r4
    @(negedge clk);
    a_ie = 1'b1; a_ia = 5'd4;
    @(negedge clk);
    a_we = 1'b1; a_wa = 5'd4; a_wd = 32'h00000044; #2;
    push("a_count_r4_issued", 32'd2);   check({26'd0, a_bc});
    @(negedge clk);
    a_idle(); a_ra1 = 5'd4; #2;
    push("a_r4_data", 32'h44);          check(a_rd1);
    push("a_r4_still_busy", 32'd1);     check({31'd0, a_rb1});
    push("a_r4_count_same", 32'd2);     check({26'd0, a_bc});

    // Flush with concurrent issue r6 and write r2
    @(negedge clk);
    a_fl = 1'b1; a_ie = 1'b1; a_ia = 5'd6; a_we = 1'b1; a_wa = 5'd2; a_wd = 32'hA5;
    @(negedge clk);
    a_idle(); a_ra1 = 5'd6; a_ra2 = 5'd2; #2;
    push("a_flush_count", 32'd0);       check({26'd0, a_bc});
    push("a_flush_r6_busy", 32'd0);     check({31'd0, a_rb1});
    push("a_flush_r2_data", 32'hA5);    check(a_rd2);
    a_ra1 = 5'd4; #1;
    push("a_flush_r4_busy", 32'd0);     check({31'd0, a_rb1});

    // ---------------- Instance B ----------------
    @(negedge clk);
    b_we = 1'b1; b_wa = 3'd0; b_wd = 16'hBEEF; b_ie = 1'b1; b_ia = 3'd0;
    b_ra1 = 3'd0; #2;
    push("b_r0_bypass", 32'hBEEF);      check({16'd0, b_rd1});
    @(negedge clk);
    b_idle(); #2;
    push("b_r0_stored", 32'hBEEF);      check({16'd0, b_rd1});
    push("b_r0_busy", 32'd1);           check({31'd0, b_rb1});
    push("b_r0_count", 32'd1);          check({28'd0, b_bc});

    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      b_ie = 1'b1; b_ia = 3'(i);
    end
    @(negedge clk);
    b_idle(); b_ra1 = 3'd7; #2;
    push("b_all_busy_count", 32'd8);    check({28'd0, b_bc});
    push("b_r7_busy", 32'd1);           check({31'd0, b_rb1});

    @(negedge clk);
    b_fl = 1'b1; b_ie = 1'b1; b_ia = 3'd6; b_we = 1'b1; b_wa = 3'd2; b_wd = 16'h00A5;
    @(negedge clk);
    b_idle(); b_ra1 = 3'd6; b_ra2 = 3'd2; #2;
    push("b_flush_count", 32'd0);       check({28'd0, b_bc});
    push("b_flush_r6_busy", 32'd0);     check({31'd0, b_rb1});
    push("b_flush_r2_data", 32'hA5);    check({16'd0, b_rd2});

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
